// File: rtl/status_reg.sv
// rtl/status_reg.sv - Jac1-8 processor status (flag) register
//
// Purpose:
//   Holds the CPU flag bits. On cycles where the current instruction updates
//   flags, the register loads either the ALU flag outputs or the decoder's
//   explicit flag values. The registered value is the status bus read by the
//   decoder/sequencer.
//
// Ports:
//   clk                      in   1              rising-edge clock
//   res_n                    in   1              synchronous reset, active-high despite the name
//   wr_en                    in   1              1 = load selected source this edge, 0 = hold
//   sel_stat_in_alu_decoder  in   1              1 = alu_status, 0 = dec_status
//   alu_status               in   NumStatusBits  ALU flag results
//   dec_status               in   NumStatusBits  decoder flag set/clear values
//   status                   out  NumStatusBits  registered flag contents

module status_reg #(
  parameter int NumStatusBits = 6
) (
  input  logic                     clk,
  input  logic                     res_n,
  input  logic                     wr_en,
  input  logic                     sel_stat_in_alu_decoder,
  input  logic [NumStatusBits-1:0] alu_status,
  input  logic [NumStatusBits-1:0] dec_status,
  output logic [NumStatusBits-1:0] status
);

  // 2:1 source mux; only consulted on write cycles, so the unselected bus
  // never reaches the register.
  logic [NumStatusBits-1:0] load_value;

  always_comb begin
    load_value = dec_status;
    if (sel_stat_in_alu_decoder) begin
      load_value = alu_status;
    end
  end

  // Reset outranks any pending write in the same cycle.
  always_ff @(posedge clk) begin
    if (res_n) begin
      status <= '0;
    end else if (wr_en) begin
      status <= load_value;
    end
  end

endmodule

// File: tb/tb_status_reg.sv
// tb/tb_status_reg.sv - scoreboard bench for status_reg

module tb_status_reg;

  localparam int W = 6;

  logic         clk;
  logic         res_n;
  logic         wr_en;
  logic         sel;
  logic [W-1:0] alu;
  logic [W-1:0] dec;
  logic [W-1:0] status;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model;
  logic [W-1:0] exp_v;
  int           checks;
  int           errors;

  status_reg #(.NumStatusBits(W)) dut (
    .clk                     (clk),
    .res_n                   (res_n),
    .wr_en                   (wr_en),
    .sel_stat_in_alu_decoder (sel),
    .alu_status              (alu),
    .dec_status              (dec),
    .status                  (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, predict the post-edge value, push it, and
  // advance to just after the edge so the caller can compare.
  task automatic apply(input logic r, input logic we, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] d);
    res_n = r;
    wr_en = we;
    sel   = s;
    alu   = a;
    dec   = d;
    if (r)       model = '0;
    else if (we) model = s ? a : d;
    exp_q.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000);
    checks++;
    exp_v = exp_q.pop_front();
    if (status !== exp_v) begin
      errors++;
      $display("FAIL reset: status=%b expected=%b", status, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000);
      checks++;
      exp_v = exp_q.pop_front();
      if (status !== 6'b000000 || status !== exp_v) begin
        errors++;
        $display("FAIL reset_idle[%0d]: status=%b expected=%b", i, status, exp_v);
      end
    end
  endtask

  task automatic test_alu_load();
    logic [W-1:0] seq [3];
    seq[0] = 6'b000001;
    seq[1] = 6'b000010;
    seq[2] = 6'b000000;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b1, 1'b1, seq[i], 6'b000011);
      checks++;
      exp_v = exp_q.pop_front();
      if (status !== exp_v) begin
        errors++;
        $display("FAIL alu_load[%0d]: status=%b expected=%b", i, status, exp_v);
      end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 1'b1, 6'b000001, 6'b010101);
      checks++;
      exp_v = exp_q.pop_front();
      if (status !== 6'b000000 || status !== exp_v) begin
        errors++;
        $display("FAIL hold[%0d]: status=%b expected=%b", i, status, exp_v);
      end
    end
  endtask

  task automatic test_dec_load();
    apply(1'b0, 1'b1, 1'b0, 6'b000001, 6'b000011);
    checks++;
    exp_v = exp_q.pop_front();
    if (status !== exp_v) begin
      errors++;
      $display("FAIL dec_load: status=%b expected=%b", status, exp_v);
    end
  endtask

  task automatic test_reset_priority();
    apply(1'b0, 1'b1, 1'b1, 6'b111111, 6'b000000);
    checks++;
    exp_v = exp_q.pop_front();
    if (status !== 6'b111111 || status !== exp_v) begin
      errors++;
      $display("FAIL prio_preload: status=%b expected=%b", status, exp_v);
    end
    apply(1'b1, 1'b1, 1'b1, 6'b101010, 6'b010101);
    checks++;
    exp_v = exp_q.pop_front();
    if (status !== 6'b000000 || status !== exp_v) begin
      errors++;
      $display("FAIL reset_priority: status=%b expected=%b", status, exp_v);
    end
  endtask

  task automatic test_isolation();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 6'b111111 : 6'b010101, 6'b100000);
      checks++;
      exp_v = exp_q.pop_front();
      if (status !== 6'b100000 || status !== exp_v) begin
        errors++;
        $display("FAIL isolation[%0d]: status=%b expected=%b", i, status, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      apply(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, W'($urandom), W'($urandom));
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL back_to_back[%0d]: scoreboard empty", i);
      end else begin
        exp_v = exp_q.pop_front();
        if (status !== exp_v) begin
          errors++;
          $display("FAIL back_to_back[%0d]: status=%b expected=%b", i, status, exp_v);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model  = 'x;
    res_n  = 1'b0;
    wr_en  = 1'b0;
    sel    = 1'b0;
    alu    = '0;
    dec    = '0;
    @(negedge clk);
    test_reset();
    test_alu_load();
    test_hold();
    test_dec_load();
    test_reset_priority();
    test_isolation();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
